// File: rtl/branch2_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : branch2_scheduler_if
// Brief    : Control/address bundle between branch2_scheduler and the
//            branch-metric block, its input buffers and the readback consumer.
// Revision : 1.0  initial release
// ============================================================================
interface branch2_scheduler_if #(
    parameter int AW = 12
);
    logic          i_start;
    logic          i_abort;
    logic          i_hold;
    logic          o_src_rd_en;
    logic [AW-1:0] o_src_addr;
    logic          o_calc_valid;
    logic [AW-1:0] o_calc_addr;
    logic [AW-1:0] o_branch_addr;
    logic          o_rd_valid;
    logic [AW-1:0] o_rd_index;
    logic          o_rd_dir;
    logic          o_rd_last;
    logic          o_busy;
    logic          o_done;

    // Scheduler side
    modport master (
        input  i_start, i_abort, i_hold,
        output o_src_rd_en, o_src_addr, o_calc_valid, o_calc_addr,
               o_branch_addr, o_rd_valid, o_rd_index, o_rd_dir,
               o_rd_last, o_busy, o_done
    );

    // Controller / consumer side
    modport slave (
        output i_start, i_abort, i_hold,
        input  o_src_rd_en, o_src_addr, o_calc_valid, o_calc_addr,
               o_branch_addr, o_rd_valid, o_rd_index, o_rd_dir,
               o_rd_last, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/branch2_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : branch2_scheduler
// Brief    : Sequencer for one SISO branch-metric block: streams a frame into
//            the calc service, waits for the last metric to commit, then
//            replays the metrics ascending (alpha) and descending (beta).
// Revision : 1.0  initial release
// ============================================================================
module branch2_scheduler #(
    parameter int DWIDTH       = 16,
    parameter int BRANCH_SIZE  = 3072,
    parameter int SRC_LATENCY  = 1,
    parameter int CALC_LATENCY = 2,
    parameter int RD_LATENCY   = 1
) (
    input  wire logic           aclk,
    input  wire logic           aresetn,
    branch2_scheduler_if.master bus
);

    localparam int c_AW   = (BRANCH_SIZE > 1) ? $clog2(BRANCH_SIZE) : 1;
    // Drain length: input-buffer latency + calc latency + one write cycle
    localparam int c_D    = SRC_LATENCY + CALC_LATENCY + 1;
    localparam int c_WMAX = (c_D > RD_LATENCY) ? c_D : RD_LATENCY;
    localparam int c_WW   = $clog2(c_WMAX) + 1;

    localparam logic [c_AW-1:0] c_LAST      = c_AW'(BRANCH_SIZE - 1);
    localparam logic [c_WW-1:0] c_DRAIN_END = c_WW'(c_D - 1);
    localparam logic [c_WW-1:0] c_FLUSH_END = c_WW'(RD_LATENCY - 1);

    // Reject configurations the timing model cannot honour
    if (DWIDTH < 1 || BRANCH_SIZE < 2 || SRC_LATENCY < 1 ||
        CALC_LATENCY < 1 || RD_LATENCY < 1) begin : g_param_check
        $error("branch2_scheduler: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_FWD   = 3'd3,
        S_BWD   = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q;
    logic [c_WW-1:0]    wait_q;         // DRAIN / FLUSH cycle counter
    logic               src_rd_en_q;
    logic [c_AW-1:0]    src_addr_q;     // doubles as the FILL counter
    logic [c_AW-1:0]    branch_addr_q;  // doubles as the FWD/BWD counter
    logic               busy_q;
    logic               done_q;

    // Input-buffer alignment shift register (calc issue side)
    logic [SRC_LATENCY-1:0]           calc_vld_q;
    logic [SRC_LATENCY-1:0][c_AW-1:0] calc_addr_q;

    // Readback tag pipeline, RD_LATENCY deep, never stalled by hold
    logic [RD_LATENCY-1:0]            rd_vld_q;
    logic [RD_LATENCY-1:0][c_AW-1:0]  rd_idx_q;
    logic [RD_LATENCY-1:0]            rd_dir_q;
    logic [RD_LATENCY-1:0]            rd_last_q;

    // Next tag entering the readback pipeline
    logic            tag_vld_d;
    logic [c_AW-1:0] tag_idx_d;
    logic            tag_dir_d;
    logic            tag_last_d;

    // Build the readback tag for an issue in FWD/BWD when not held
    always_comb begin
        tag_vld_d  = 1'b0;
        tag_idx_d  = branch_addr_q;
        tag_dir_d  = 1'b0;
        tag_last_d = 1'b0;
        if (!bus.i_hold) begin
            if (state_q == S_FWD) begin
                tag_vld_d  = 1'b1;
                tag_last_d = (branch_addr_q == c_LAST);
            end else if (state_q == S_BWD) begin
                tag_vld_d  = 1'b1;
                tag_dir_d  = 1'b1;
                tag_last_d = (branch_addr_q == '0);
            end
        end
    end

    // Main sequencer: state, counters and registered control outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            src_rd_en_q   <= 1'b0;
            src_addr_q    <= '0;
            branch_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (bus.i_abort) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            src_rd_en_q   <= 1'b0;
            src_addr_q    <= '0;
            branch_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_start) begin
                        state_q     <= S_FILL;
                        src_rd_en_q <= 1'b1;
                        src_addr_q  <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                S_FILL: begin
                    // Compare before incrementing so the count stops at N-1
                    if (src_addr_q == c_LAST) begin
                        state_q     <= S_DRAIN;
                        src_rd_en_q <= 1'b0;
                        src_addr_q  <= '0;
                        wait_q      <= '0;
                    end else begin
                        src_addr_q  <= src_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (wait_q == c_DRAIN_END) begin
                        state_q       <= S_FWD;
                        branch_addr_q <= '0;
                    end else begin
                        wait_q        <= wait_q + 1'b1;
                    end
                end
                S_FWD: begin
                    if (!bus.i_hold) begin
                        if (branch_addr_q == c_LAST) begin
                            state_q       <= S_BWD;
                            branch_addr_q <= c_LAST;
                        end else begin
                            branch_addr_q <= branch_addr_q + 1'b1;
                        end
                    end
                end
                S_BWD: begin
                    if (!bus.i_hold) begin
                        if (branch_addr_q == '0) begin
                            state_q <= S_FLUSH;
                            wait_q  <= '0;
                        end else begin
                            branch_addr_q <= branch_addr_q - 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (wait_q == c_FLUSH_END) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Delay lines: calc issue aligned to buffer data, tags aligned to RAM data
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            calc_vld_q  <= '0;
            calc_addr_q <= '0;
            rd_vld_q    <= '0;
            rd_idx_q    <= '0;
            rd_dir_q    <= '0;
            rd_last_q   <= '0;
        end else if (bus.i_abort) begin
            calc_vld_q  <= '0;
            calc_addr_q <= '0;
            rd_vld_q    <= '0;
            rd_idx_q    <= '0;
            rd_dir_q    <= '0;
            rd_last_q   <= '0;
        end else begin
            calc_vld_q[0]  <= src_rd_en_q;
            calc_addr_q[0] <= src_addr_q;
            for (int i = 1; i < SRC_LATENCY; i++) begin
                calc_vld_q[i]  <= calc_vld_q[i-1];
                calc_addr_q[i] <= calc_addr_q[i-1];
            end
            rd_vld_q[0]  <= tag_vld_d;
            rd_idx_q[0]  <= tag_idx_d;
            rd_dir_q[0]  <= tag_dir_d;
            rd_last_q[0] <= tag_last_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_idx_q[i]  <= rd_idx_q[i-1];
                rd_dir_q[i]  <= rd_dir_q[i-1];
                rd_last_q[i] <= rd_last_q[i-1];
            end
        end
    end

    assign bus.o_src_rd_en   = src_rd_en_q;
    assign bus.o_src_addr    = src_addr_q;
    assign bus.o_calc_valid  = calc_vld_q[SRC_LATENCY-1];
    assign bus.o_calc_addr   = calc_addr_q[SRC_LATENCY-1];
    assign bus.o_branch_addr = branch_addr_q;
    assign bus.o_rd_valid    = rd_vld_q[RD_LATENCY-1];
    assign bus.o_rd_index    = rd_idx_q[RD_LATENCY-1];
    assign bus.o_rd_dir      = rd_dir_q[RD_LATENCY-1];
    assign bus.o_rd_last     = rd_last_q[RD_LATENCY-1];
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;

endmodule
`default_nettype wire

// File: doc/branch2_scheduler.md
# branch2_scheduler

Sequencing controller for one SISO-decoder branch-metric block (calc service plus its 1-D branch RAM). On a start pulse it streams a frame of `BRANCH_SIZE` systematic/parity pairs from the input buffers into the calc service. It then waits for the last metric to commit, and replays the stored metrics twice: once in ascending order for the forward (alpha) recursion and once in descending order for the backward (beta) recursion. It owns all addressing of the branch block and of the input buffers.

## Interface
- `DWIDTH`, 16: metric width; unused internally, kept for integration symmetry.
- `BRANCH_SIZE`, 3072: items per frame (N). Need not be a power of two. AW = `$clog2(BRANCH_SIZE)`.
- `SRC_LATENCY`, 1: input-buffer read latency in cycles (≥1).
- `CALC_LATENCY`, 2: cycles from calc `i_valid` to the RAM write strobe (≥1).
- `RD_LATENCY`, 1: branch-RAM read latency, from `o_addr` to `o_data` (≥1).

Ports:
- `aclk`  in  1  clock; single clock domain.
- `aresetn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  frame start pulse; ignored unless IDLE.
- `i_abort`  in  1  synchronous abort; highest priority after reset.
- `i_hold`  in  1  downstream stall during FWD/BWD.
- `o_src_rd_en`  out  1  input-buffer read enable.
- `o_src_addr`  out  AW  input-buffer read address.
- `o_calc_valid`  out  1  to branch block `i_valid`.
- `o_calc_addr`  out  AW  to branch block `i_addr`.
- `o_branch_addr`  out  AW  to branch block `o_addr`.
- `o_rd_valid`  out  1  branch `o_data` is valid this cycle.
- `o_rd_index`  out  AW  trellis index of the current `o_data`.
- `o_rd_dir`  out  1  0 = forward pass, 1 = backward pass (qualified by `o_rd_valid`).
- `o_rd_last`  out  1  last item of the current pass.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE → FILL → DRAIN → FWD → BWD → FLUSH → DONE → IDLE. State, counters and the output side of every delay line are registered.
- IDLE:
  - `i_start`=1 moves to FILL; the counter is loaded with 0.
- FILL:
  - Each cycle: `o_src_rd_en`=1, `o_src_addr`=cnt, then cnt+1.
  - At cnt=N-1 → DRAIN. The counter must terminate at N-1 and never wrap through 2^AW-1.
  - `i_hold` is ignored in FILL.
- Calc issue:
  - `o_calc_valid`/`o_calc_addr` are `o_src_rd_en`/`o_src_addr` delayed by exactly SRC_LATENCY cycles through a shift register, so they align with the input-buffer data.
- DRAIN:
  - Waits D = SRC_LATENCY+CALC_LATENCY+1 cycles after the last FILL cycle, so the last metric is written before the first readback.
  - Then → FWD with cnt=0.
- FWD:
  - Drives `o_branch_addr`=cnt.
  - An issue occurs on each cycle with `i_hold`=0; cnt then increments.
  - With `i_hold`=1 the address and cnt are frozen and nothing is issued.
  - After issuing N-1 → BWD with cnt=N-1.
- BWD:
  - Same as FWD, but descending to 0.
  - After issuing 0 → FLUSH.
- Readback tags:
  - Each issue pushes {index, dir, last} into a RD_LATENCY-deep valid pipeline.
  - Its output drives `o_rd_valid`/`o_rd_index`/`o_rd_dir`/`o_rd_last`.
  - This pipeline is not stalled by `i_hold`: up to RD_LATENCY items already issued still emerge after hold rises. Downstream must absorb them.
- FLUSH: waits RD_LATENCY cycles, then → DONE.
- DONE: `o_done`=1 for one cycle, then → IDLE.
- Abort:
  - `i_abort`=1 in any state → IDLE on the next edge.
  - All counters and all delay pipelines are cleared, so no `o_calc_valid` or `o_rd_valid` follows the abort.
  - `o_done` is not pulsed.
  - `i_start` asserted in the same cycle as `i_abort` is ignored.
- `i_start` outside IDLE is ignored: no restart, no queueing.

## Timing
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; all pipelines empty.
- `i_start` sampled at edge k: FILL occupies cycles k+1..k+N; `o_src_addr`=0 at k+1.
- First `o_calc_valid` at k+1+SRC_LATENCY; the last at k+N+SRC_LATENCY.
- FWD begins at k+N+D+1. With no hold, `o_rd_valid` first rises RD_LATENCY cycles later with index 0.
- No-hold frame length, start edge to `o_done` high: N + D + 2N + RD_LATENCY + 1 cycles.
- `o_rd_valid` is continuous across the FWD→BWD boundary when there is no hold:
  - index N-1 (dir 0, last 1),
  - then N-1 (dir 1),
  - …, down to 0 (dir 1, last 1).
- `o_busy` rises the cycle after start and falls the cycle after DONE; it is low in the same cycle IDLE is re-entered.
- The index output is the tagged address, never recomputed from cnt.

## Test plan
- N=8, defaults, single start, no hold:
  - `o_calc_addr` sequence 0..7 on 8 consecutive cycles.
  - `o_rd_index` sequence 0..7 (dir 0), then 7..0 (dir 1).
  - `o_rd_last` high on the 8th and 16th valid.
  - `o_done` exactly 8+4+16+1+1=30 cycles after the start edge.
- N=6 (non-power-of-two): FILL issues addresses 0..5 only; address 6 or 7 never appears on any address port.
- Hold: hold 3 cycles at FWD index 3 and 2 cycles in BWD:
  - exactly one more valid emerges after each hold rise;
  - no index is skipped or duplicated;
  - `o_done` is delayed by exactly 5 cycles.
- `i_start` pulsed during FILL and again during BWD: ignored; exactly one `o_done` per accepted start.
- Abort:
  - `i_abort` mid-FWD: IDLE next cycle; `o_busy`=0; no further `o_rd_valid`; no `o_done`.
  - A new start afterward completes normally.
- Reset mid-FILL: asynchronous `aresetn` low forces all outputs to 0 immediately, without waiting for a clock edge. After release, a fresh start reproduces the first scenario's timing.
